// File: rtl/qdma_stm_h2c_hdr_ins.sv
// H2C streaming header-insertion stage.
// Input beats are buffered in a small FIFO. A two-state FSM optionally emits one
// header beat per packet, built from the packet's qid and first-beat metadata,
// ahead of the payload. Output is a single registered AXI-Stream slot whose
// tdest is taken from qid. Wrapping packet and header counters sit on the output.
module qdma_stm_h2c_hdr_ins #(
    parameter int DATA_WIDTH = 512,
    parameter int QID_BITS   = 11,
    parameter int MDATA_BITS = 32,
    parameter int TDEST_BITS = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         in_axis_tdata,
    input  logic [QID_BITS-1:0]           in_axis_tqid,
    input  logic [MDATA_BITS-1:0]         in_axis_tmdata,
    input  logic                          in_axis_tlast,
    input  logic                          in_axis_tvalid,
    output logic                          in_axis_tready,
    input  logic                          cfg_hdr_en,
    output logic [DATA_WIDTH-1:0]         out_axis_tdata,
    output logic [TDEST_BITS-1:0]         out_axis_tdest,
    output logic                          out_axis_tuser,
    output logic                          out_axis_tlast,
    output logic                          out_axis_tvalid,
    input  logic                          out_axis_tready,
    input  logic                          stat_clr,
    output logic [31:0]                   stat_pkt_cnt,
    output logic [31:0]                   stat_hdr_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {SOP, PLD} state_t;

    // Header beat: qid in [15:0], flow_id and tdest (qid[5:0]) in the next two
    // bytes, metadata zero-extended into [79:32]; all remaining bits zero.
    function automatic logic [DATA_WIDTH-1:0] build_hdr(input logic [QID_BITS-1:0]   qid,
                                                        input logic [MDATA_BITS-1:0] mdata);
        logic [DATA_WIDTH-1:0] h;
        logic [5:0]            qid6;
        qid6     = 6'(qid);
        h        = '0;
        h[15:0]  = 16'(qid);
        h[23:16] = {2'b00, qid6};
        h[31:24] = {2'b00, qid6};
        h[79:32] = 48'(mdata);
        return h;
    endfunction

    function automatic logic [TDEST_BITS-1:0] qid_to_tdest(input logic [QID_BITS-1:0] qid);
        return TDEST_BITS'(6'(qid));
    endfunction

    // FIFO storage and control
    logic [DATA_WIDTH-1:0] mem_data  [FIFO_DEPTH];
    logic [QID_BITS-1:0]   mem_qid   [FIFO_DEPTH];
    logic [MDATA_BITS-1:0] mem_mdata [FIFO_DEPTH];
    logic                  mem_last  [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  push;
    logic                  pop;

    // FIFO head (stage p0)
    logic                  head_vld_p0;
    logic [DATA_WIDTH-1:0] head_data_p0;
    logic [QID_BITS-1:0]   head_qid_p0;
    logic [MDATA_BITS-1:0] head_mdata_p0;
    logic                  head_last_p0;

    // Output slot (stage p1)
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [TDEST_BITS-1:0] dest_p1;
    logic                  user_p1;
    logic                  last_p1;

    state_t                state_q;
    state_t                state_d;
    logic                  load;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic                  nxt_user;
    logic                  nxt_last;
    logic                  slot_free;
    logic                  xfer;
    logic [31:0]           pkt_cnt_q;
    logic [31:0]           hdr_cnt_q;

    // Ready depends only on registered occupancy, so a same-cycle pop never bypasses it.
    assign in_axis_tready = (cnt < CW'(FIFO_DEPTH));
    assign push           = in_axis_tvalid && in_axis_tready;
    assign fifo_cnt       = cnt;

    assign head_vld_p0    = (cnt != '0);
    assign head_data_p0   = mem_data[rd_ptr];
    assign head_qid_p0    = mem_qid[rd_ptr];
    assign head_mdata_p0  = mem_mdata[rd_ptr];
    assign head_last_p0   = mem_last[rd_ptr];

    assign slot_free      = !vld_p1 || out_axis_tready;
    assign xfer           = vld_p1 && out_axis_tready;

    // FIFO payload write; storage needs no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= in_axis_tdata;
            mem_qid[wr_ptr]   <= in_axis_tqid;
            mem_mdata[wr_ptr] <= in_axis_tmdata;
            mem_last[wr_ptr]  <= in_axis_tlast;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SOP;
        else     state_q <= state_d;
    end

    // Next state and output-slot load decision; cfg_hdr_en only matters at SOP.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        pop      = 1'b0;
        nxt_data = head_data_p0;
        nxt_user = 1'b0;
        nxt_last = head_last_p0;
        if (slot_free && head_vld_p0) begin
            load = 1'b1;
            unique case (state_q)
                SOP: begin
                    if (cfg_hdr_en) begin
                        nxt_data = build_hdr(head_qid_p0, head_mdata_p0);
                        nxt_user = 1'b1;
                        nxt_last = 1'b0;
                        state_d  = PLD;
                    end else begin
                        pop     = 1'b1;
                        state_d = head_last_p0 ? SOP : PLD;
                    end
                end
                PLD: begin
                    pop = 1'b1;
                    if (head_last_p0) state_d = SOP;
                end
                default: state_d = SOP;
            endcase
        end
    end

    // Output register: loads whenever the slot is free, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            dest_p1 <= '0;
            user_p1 <= 1'b0;
            last_p1 <= 1'b0;
        end else if (slot_free) begin
            vld_p1 <= load;
            if (load) begin
                data_p1 <= nxt_data;
                dest_p1 <= qid_to_tdest(head_qid_p0);
                user_p1 <= nxt_user;
                last_p1 <= nxt_last;
            end
        end
    end

    // Statistics counters; clear wins over a coincident increment, both wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            hdr_cnt_q <= '0;
        end else if (stat_clr) begin
            pkt_cnt_q <= '0;
            hdr_cnt_q <= '0;
        end else begin
            if (xfer && last_p1) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (xfer && user_p1) hdr_cnt_q <= hdr_cnt_q + 32'd1;
        end
    end

    assign out_axis_tvalid = vld_p1;
    assign out_axis_tdata  = data_p1;
    assign out_axis_tdest  = dest_p1;
    assign out_axis_tuser  = user_p1;
    assign out_axis_tlast  = last_p1;
    assign stat_pkt_cnt    = pkt_cnt_q;
    assign stat_hdr_cnt    = hdr_cnt_q;

endmodule

// File: tb/tb_qdma_stm_h2c_hdr_ins.sv
// Bench for qdma_stm_h2c_hdr_ins: packet-level reference model of the expected
// output beat stream and counters, compared against a monitor of output transfers.
`timescale 1ns/1ps
module tb_qdma_stm_h2c_hdr_ins;
    localparam int DW = 512;
    localparam int QB = 11;
    localparam int MB = 32;
    localparam int TB = 16;
    localparam int FD = 4;
    localparam int CW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_axis_tdata = '0;
    logic [QB-1:0] in_axis_tqid = '0;
    logic [MB-1:0] in_axis_tmdata = '0;
    logic          in_axis_tlast = 1'b0;
    logic          in_axis_tvalid = 1'b0;
    logic          in_axis_tready;
    logic          cfg_hdr_en = 1'b1;
    logic [DW-1:0] out_axis_tdata;
    logic [TB-1:0] out_axis_tdest;
    logic          out_axis_tuser;
    logic          out_axis_tlast;
    logic          out_axis_tvalid;
    logic          out_axis_tready = 1'b1;
    logic          stat_clr = 1'b0;
    logic [31:0]   stat_pkt_cnt;
    logic [31:0]   stat_hdr_cnt;
    logic [CW-1:0] fifo_cnt;

    qdma_stm_h2c_hdr_ins #(
        .DATA_WIDTH(DW), .QID_BITS(QB), .MDATA_BITS(MB), .TDEST_BITS(TB), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .in_axis_tdata(in_axis_tdata), .in_axis_tqid(in_axis_tqid),
        .in_axis_tmdata(in_axis_tmdata), .in_axis_tlast(in_axis_tlast),
        .in_axis_tvalid(in_axis_tvalid), .in_axis_tready(in_axis_tready),
        .cfg_hdr_en(cfg_hdr_en),
        .out_axis_tdata(out_axis_tdata), .out_axis_tdest(out_axis_tdest),
        .out_axis_tuser(out_axis_tuser), .out_axis_tlast(out_axis_tlast),
        .out_axis_tvalid(out_axis_tvalid), .out_axis_tready(out_axis_tready),
        .stat_clr(stat_clr), .stat_pkt_cnt(stat_pkt_cnt), .stat_hdr_cnt(stat_hdr_cnt),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TB-1:0] dest;
        logic          user;
        logic          last;
    } beat_t;

    beat_t       rx[$];
    beat_t       exp_q[$];
    int          rx_rd = 0;
    int          exp_rd = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_pkt = '0;
    logic [31:0] exp_hdr = '0;

    // Output monitor: samples shortly before the rising edge at which a transfer occurs.
    always @(negedge clk) begin : mon
        beat_t b;
        #3;
        if (!rst && out_axis_tvalid && out_axis_tready) begin
            b.data = out_axis_tdata;
            b.dest = out_axis_tdest;
            b.user = out_axis_tuser;
            b.last = out_axis_tlast;
            rx.push_back(b);
        end
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // Reference: what one packet must look like on the output, from qid, first-beat mdata and mode.
    function automatic void model_pkt(input logic [QB-1:0] q, input logic [MB-1:0] m,
                                      input logic [DW-1:0] d[$], input bit hdr);
        int unsigned qv;
        beat_t       b;
        qv     = 32'(q);
        b.dest = TB'(qv % 64);
        if (hdr) begin
            b.data = DW'(qv % 65536) | (DW'(qv % 64) << 16) | (DW'(qv % 64) << 24) | (DW'(m) << 32);
            b.user = 1'b1;
            b.last = 1'b0;
            exp_q.push_back(b);
            exp_hdr += 32'd1;
        end
        foreach (d[i]) begin
            b.data = d[i];
            b.user = 1'b0;
            b.last = (i == d.size() - 1);
            exp_q.push_back(b);
        end
        exp_pkt += 32'd1;
    endfunction

    // Presents one input beat and returns at the falling edge after it was accepted.
    task automatic drive_beat(input logic [DW-1:0] d, input logic [QB-1:0] q,
                              input logic [MB-1:0] m, input bit last);
        int n = 0;
        in_axis_tdata  = d;
        in_axis_tqid   = q;
        in_axis_tmdata = m;
        in_axis_tlast  = last;
        in_axis_tvalid = 1'b1;
        while (!in_axis_tready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL drive_timeout: in_axis_tready=%b after %0d cycles, want 1", in_axis_tready, n);
        end
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic [QB-1:0] q, input logic [MB-1:0] m0, input int nb, input bit hdr);
        logic [DW-1:0] d[$];
        for (int i = 0; i < nb; i++) d.push_back(rand_data());
        model_pkt(q, m0, d, hdr);
        for (int i = 0; i < nb; i++)
            drive_beat(d[i], q, (i == 0) ? m0 : MB'($urandom), i == nb - 1);
        in_axis_tvalid = 1'b0;
    endtask

    // Waits (bounded) until the monitor has seen as many beats as the model expects, then idles a little.
    task automatic wait_rx();
        int n = 0;
        while ((rx.size() - rx_rd) < (exp_q.size() - exp_rd) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (out_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b, want 0", out_axis_tvalid); end
        n_chk++; if (out_axis_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h, want 0", out_axis_tdata); end
        n_chk++; if (out_axis_tdest !== '0) begin n_fail++; $display("FAIL reset_tdest: got %h, want 0", out_axis_tdest); end
        n_chk++; if (out_axis_tuser !== 1'b0) begin n_fail++; $display("FAIL reset_tuser: got %b, want 0", out_axis_tuser); end
        n_chk++; if (out_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b, want 0", out_axis_tlast); end
        n_chk++; if (fifo_cnt !== '0) begin n_fail++; $display("FAIL reset_fifo_cnt: got %0d, want 0", fifo_cnt); end
        n_chk++; if (stat_pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d, want 0", stat_pkt_cnt); end
        n_chk++; if (stat_hdr_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_hdr_cnt: got %0d, want 0", stat_hdr_cnt); end
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (in_axis_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b, want 1", in_axis_tready); end
    endtask

    task automatic test_hdr_basic();
        int h;
        cfg_hdr_en      = 1'b1;
        out_axis_tready = 1'b1;
        h = rx_rd;
        send_pkt(11'h045, 32'hDEAD_BEEF, 3, 1'b1);
        wait_rx();
        n_chk++;
        if (rx.size() - h != 4) begin n_fail++; $display("FAIL hdr_basic_count: got %0d beats, want 4", rx.size() - h); end
        if (rx.size() - h >= 4) begin
            n_chk++; if (rx[h].data[15:0] !== 16'h0045) begin n_fail++; $display("FAIL hdr_qid: got %h, want 0045", rx[h].data[15:0]); end
            n_chk++; if (rx[h].data[23:16] !== 8'h05) begin n_fail++; $display("FAIL hdr_flow_id: got %h, want 05", rx[h].data[23:16]); end
            n_chk++; if (rx[h].data[31:24] !== 8'h05) begin n_fail++; $display("FAIL hdr_tdest_field: got %h, want 05", rx[h].data[31:24]); end
            n_chk++; if (rx[h].data[79:32] !== 48'h0000_DEAD_BEEF) begin n_fail++; $display("FAIL hdr_mdata: got %h, want 0000deadbeef", rx[h].data[79:32]); end
            n_chk++; if (rx[h].user !== 1'b1) begin n_fail++; $display("FAIL hdr_tuser: got %b, want 1", rx[h].user); end
            n_chk++; if (rx[h+3].last !== 1'b1) begin n_fail++; $display("FAIL hdr_last_beat_tlast: got %b, want 1", rx[h+3].last); end
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (rx[h+i].dest !== 16'd5) begin n_fail++; $display("FAIL hdr_tdest beat %0d: got %0d, want 5", i, rx[h+i].dest); end
            end
        end
        while (rx_rd < rx.size() && exp_rd < exp_q.size()) begin
            n_chk++;
            if (rx[rx_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL hdr_basic_beat %0d: got %h, want %h", rx_rd - h, rx[rx_rd], exp_q[exp_rd]); end
            rx_rd++; exp_rd++;
        end
        rx_rd = rx.size(); exp_rd = exp_q.size();
        n_chk++; if (stat_hdr_cnt !== 32'd1) begin n_fail++; $display("FAIL hdr_basic_hdr_cnt: got %0d, want 1", stat_hdr_cnt); end
        n_chk++; if (stat_pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL hdr_basic_pkt_cnt: got %0d, want 1", stat_pkt_cnt); end
    endtask

    task automatic test_passthrough();
        int h;
        cfg_hdr_en = 1'b0;
        h = rx_rd;
        send_pkt(QB'($urandom), MB'($urandom), 1, 1'b0);
        send_pkt(QB'($urandom), MB'($urandom), 1, 1'b0);
        wait_rx();
        n_chk++;
        if (rx.size() - h != 2) begin n_fail++; $display("FAIL pass_count: got %0d beats, want 2", rx.size() - h); end
        while (rx_rd < rx.size() && exp_rd < exp_q.size()) begin
            n_chk++;
            if (rx[rx_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL pass_beat %0d: got %h, want %h", rx_rd - h, rx[rx_rd], exp_q[exp_rd]); end
            rx_rd++; exp_rd++;
        end
        rx_rd = rx.size(); exp_rd = exp_q.size();
        n_chk++; if (stat_hdr_cnt !== exp_hdr) begin n_fail++; $display("FAIL pass_hdr_cnt: got %0d, want %0d", stat_hdr_cnt, exp_hdr); end
        n_chk++; if (stat_pkt_cnt !== exp_pkt) begin n_fail++; $display("FAIL pass_pkt_cnt: got %0d, want %0d", stat_pkt_cnt, exp_pkt); end
    endtask

    task automatic test_mode_toggle();
        logic [DW-1:0] d[$];
        logic [QB-1:0] q;
        logic [MB-1:0] m;
        int            h;
        h = rx_rd;
        cfg_hdr_en = 1'b1;
        q = QB'($urandom);
        m = MB'($urandom);
        for (int i = 0; i < 4; i++) d.push_back(rand_data());
        model_pkt(q, m, d, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_beat(d[i], q, (i == 0) ? m : MB'($urandom), i == 3);
            if (i == 1) cfg_hdr_en = 1'b0;
        end
        in_axis_tvalid = 1'b0;
        send_pkt(QB'($urandom), MB'($urandom), 2, 1'b0);
        wait_rx();
        n_chk++;
        if (rx.size() - h != 7) begin n_fail++; $display("FAIL toggle_count: got %0d beats, want 7", rx.size() - h); end
        while (rx_rd < rx.size() && exp_rd < exp_q.size()) begin
            n_chk++;
            if (rx[rx_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL toggle_beat %0d: got %h, want %h", rx_rd - h, rx[rx_rd], exp_q[exp_rd]); end
            rx_rd++; exp_rd++;
        end
        rx_rd = rx.size(); exp_rd = exp_q.size();
        n_chk++; if (stat_hdr_cnt !== exp_hdr) begin n_fail++; $display("FAIL toggle_hdr_cnt: got %0d, want %0d", stat_hdr_cnt, exp_hdr); end
    endtask

    task automatic test_backpressure();
        int h;
        h = rx_rd;
        cfg_hdr_en      = 1'b1;
        out_axis_tready = 1'b0;
        fork
            send_pkt(QB'($urandom), MB'($urandom), 8, 1'b1);
            begin
                logic [DW+TB+2:0] snap;
                int               n = 0;
                while (!out_axis_tvalid && n < 50) begin @(negedge clk); n++; end
                n_chk++;
                if (!out_axis_tvalid) begin n_fail++; $display("FAIL bp_valid_timeout: tvalid=%b, want 1", out_axis_tvalid); end
                snap = {out_axis_tdata, out_axis_tdest, out_axis_tuser, out_axis_tlast, out_axis_tvalid};
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    n_chk++;
                    if ({out_axis_tdata, out_axis_tdest, out_axis_tuser, out_axis_tlast, out_axis_tvalid} !== snap) begin
                        n_fail++;
                        $display("FAIL bp_stable cycle %0d: tuser=%b tlast=%b tvalid=%b tdest=%h, want held %b %b %b %h",
                                 c, out_axis_tuser, out_axis_tlast, out_axis_tvalid, out_axis_tdest,
                                 snap[2], snap[1], snap[0], snap[TB+2:3]);
                    end
                end
                n_chk++; if (fifo_cnt !== CW'(FD)) begin n_fail++; $display("FAIL bp_fifo_full: got %0d, want %0d", fifo_cnt, FD); end
                n_chk++; if (in_axis_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready: got %b, want 0", in_axis_tready); end
                out_axis_tready = 1'b1;
            end
        join
        wait_rx();
        n_chk++;
        if (rx.size() - h != 9) begin n_fail++; $display("FAIL bp_count: got %0d beats, want 9", rx.size() - h); end
        while (rx_rd < rx.size() && exp_rd < exp_q.size()) begin
            n_chk++;
            if (rx[rx_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL bp_beat %0d: got %h, want %h", rx_rd - h, rx[rx_rd], exp_q[exp_rd]); end
            rx_rd++; exp_rd++;
        end
        rx_rd = rx.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_random();
        for (int run = 0; run < 2; run++) begin
            int h;
            int want;
            bit done;
            h          = rx_rd;
            want       = exp_q.size() - exp_rd;
            done       = 1'b0;
            cfg_hdr_en = (run == 0);
            fork
                begin
                    for (int p = 0; p < 6; p++)
                        send_pkt(QB'($urandom), MB'($urandom), $urandom_range(1, 6), run == 0);
                    done = 1'b1;
                end
                while (!done) begin
                    @(negedge clk);
                    out_axis_tready = ($urandom_range(0, 3) != 0);
                end
            join
            out_axis_tready = 1'b1;
            want = exp_q.size() - exp_rd;
            wait_rx();
            n_chk++;
            if (rx.size() - h != want) begin n_fail++; $display("FAIL rand_count run %0d: got %0d beats, want %0d", run, rx.size() - h, want); end
            while (rx_rd < rx.size() && exp_rd < exp_q.size()) begin
                n_chk++;
                if (rx[rx_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL rand_beat run %0d idx %0d: got %h, want %h", run, rx_rd - h, rx[rx_rd], exp_q[exp_rd]); end
                rx_rd++; exp_rd++;
            end
            rx_rd = rx.size(); exp_rd = exp_q.size();
            n_chk++; if (stat_pkt_cnt !== exp_pkt) begin n_fail++; $display("FAIL rand_pkt_cnt run %0d: got %0d, want %0d", run, stat_pkt_cnt, exp_pkt); end
            n_chk++; if (stat_hdr_cnt !== exp_hdr) begin n_fail++; $display("FAIL rand_hdr_cnt run %0d: got %0d, want %0d", run, stat_hdr_cnt, exp_hdr); end
        end
    endtask

    task automatic test_counter_wrap_clear();
        int n;
        cfg_hdr_en      = 1'b0;
        out_axis_tready = 1'b1;
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_q;
        @(negedge clk);
        n_chk++; if (stat_pkt_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h, want ffffffff", stat_pkt_cnt); end
        exp_pkt = 32'hFFFF_FFFF;
        send_pkt(QB'($urandom), MB'($urandom), 1, 1'b0);
        wait_rx();
        n_chk++; if (stat_pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_pkt_cnt: got %h, want 0", stat_pkt_cnt); end

        out_axis_tready = 1'b0;
        send_pkt(QB'($urandom), MB'($urandom), 1, 1'b0);
        n = 0;
        while (!(out_axis_tvalid && out_axis_tlast) && n < 50) begin @(negedge clk); n++; end
        n_chk++;
        if (!(out_axis_tvalid && out_axis_tlast)) begin n_fail++; $display("FAIL clr_setup: tvalid=%b tlast=%b, want 1 1", out_axis_tvalid, out_axis_tlast); end
        stat_clr        = 1'b1;
        out_axis_tready = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        exp_pkt  = '0;
        exp_hdr  = '0;
        n_chk++; if (stat_pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_pkt_cnt: got %0d, want 0", stat_pkt_cnt); end
        n_chk++; if (stat_hdr_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_hdr_cnt: got %0d, want 0", stat_hdr_cnt); end
        wait_rx();
        while (rx_rd < rx.size() && exp_rd < exp_q.size()) begin
            n_chk++;
            if (rx[rx_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL wrap_beat: got %h, want %h", rx[rx_rd], exp_q[exp_rd]); end
            rx_rd++; exp_rd++;
        end
        rx_rd = rx.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_reset_mid();
        logic [QB-1:0] q;
        int            h;
        cfg_hdr_en      = 1'b1;
        out_axis_tready = 1'b1;
        q = QB'($urandom);
        drive_beat(rand_data(), q, MB'($urandom), 1'b0);
        drive_beat(rand_data(), q, MB'($urandom), 1'b0);
        in_axis_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++; if (out_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_tvalid: got %b, want 0", out_axis_tvalid); end
        n_chk++; if (out_axis_tdata !== '0) begin n_fail++; $display("FAIL rmid_tdata: got %h, want 0", out_axis_tdata); end
        n_chk++; if ({out_axis_tdest, out_axis_tuser, out_axis_tlast} !== '0) begin n_fail++; $display("FAIL rmid_side: tdest=%h tuser=%b tlast=%b, want 0 0 0", out_axis_tdest, out_axis_tuser, out_axis_tlast); end
        n_chk++; if (fifo_cnt !== '0) begin n_fail++; $display("FAIL rmid_fifo_cnt: got %0d, want 0", fifo_cnt); end
        n_chk++; if (stat_pkt_cnt !== 32'd0 || stat_hdr_cnt !== 32'd0) begin n_fail++; $display("FAIL rmid_stats: pkt=%0d hdr=%0d, want 0 0", stat_pkt_cnt, stat_hdr_cnt); end
        @(negedge clk);
        rst = 1'b0;
        exp_pkt = '0;
        exp_hdr = '0;
        @(negedge clk);
        rx_rd  = rx.size();
        exp_rd = exp_q.size();
        h = rx_rd;
        send_pkt(QB'($urandom), MB'($urandom), 3, 1'b1);
        wait_rx();
        n_chk++;
        if (rx.size() - h != 4) begin n_fail++; $display("FAIL rmid_count: got %0d beats, want 4", rx.size() - h); end
        if (rx.size() > h) begin
            n_chk++; if (rx[h].user !== 1'b1) begin n_fail++; $display("FAIL rmid_first_is_hdr: got tuser=%b, want 1", rx[h].user); end
        end
        while (rx_rd < rx.size() && exp_rd < exp_q.size()) begin
            n_chk++;
            if (rx[rx_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL rmid_beat %0d: got %h, want %h", rx_rd - h, rx[rx_rd], exp_q[exp_rd]); end
            rx_rd++; exp_rd++;
        end
        rx_rd = rx.size(); exp_rd = exp_q.size();
        n_chk++; if (stat_pkt_cnt !== exp_pkt) begin n_fail++; $display("FAIL rmid_pkt_cnt: got %0d, want %0d", stat_pkt_cnt, exp_pkt); end
        n_chk++; if (stat_hdr_cnt !== exp_hdr) begin n_fail++; $display("FAIL rmid_hdr_cnt: got %0d, want %0d", stat_hdr_cnt, exp_hdr); end
    endtask

    initial begin
        test_reset();
        test_hdr_basic();
        test_passthrough();
        test_mode_toggle();
        test_backpressure();
        test_random();
        test_counter_wrap_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
